// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator: one shared period counter (edge- or center-aligned)
// drives CHANNELS registered outputs. Period and active values are double-buffered
// so they change only at a frame boundary, or straight away while the block is halted.
module pwm_multichannel #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      centerMode,
    input  logic                      load,
    input  logic [WIDTH-1:0]          periodIn,
    input  logic [CHANNELS*WIDTH-1:0] activeIn,
    output logic [CHANNELS-1:0]       pwmOut,
    output logic                      pending,
    output logic                      frameEnd
);

    typedef logic [CHANNELS-1:0][WIDTH-1:0] active_t;

    logic [WIDTH-1:0]    cnt_q, cnt_n;
    logic                dir_down_q, dir_down_n;
    logic                mode_q, mode_n;
    logic [WIDTH-1:0]    stage_p_q, stage_p_n;
    logic [WIDTH-1:0]    live_p_q, live_p_n;
    active_t             stage_a_q, stage_a_n;
    active_t             live_a_q, live_a_n;
    logic                pending_n;
    logic [CHANNELS-1:0] pwm_n;
    logic                frame_end_n;
    logic                boundary_c;
    logic                apply_c;

    // Frame boundary detection and shadow-to-live transfer condition
    always_comb begin
        boundary_c = 1'b0;
        if (mode_q) begin
            boundary_c = (live_p_q == '0) || (dir_down_q && (cnt_q == WIDTH'(1)));
        end else begin
            boundary_c = (cnt_q == '0);
        end
        apply_c = pending && (!enable || boundary_c);
    end

    // Next-state: staging, live values, mode, counter and registered outputs
    always_comb begin
        stage_p_n   = stage_p_q;
        stage_a_n   = stage_a_q;
        live_p_n    = live_p_q;
        live_a_n    = live_a_q;
        mode_n      = mode_q;
        pending_n   = pending;
        cnt_n       = cnt_q;
        dir_down_n  = dir_down_q;
        pwm_n       = '0;
        frame_end_n = 1'b0;

        // A load coincident with an apply still lands in staging and stays pending
        if (apply_c) begin
            live_p_n  = stage_p_q;
            live_a_n  = stage_a_q;
            pending_n = 1'b0;
        end
        if (load) begin
            stage_p_n = periodIn;
            stage_a_n = activeIn;
            pending_n = 1'b1;
        end

        if (!enable) begin
            mode_n = centerMode;
        end

        // Halted or at a boundary: park the counter at the start of the next frame
        if (!enable || boundary_c) begin
            cnt_n      = mode_n ? '0 : live_p_n;
            dir_down_n = 1'b0;
        end else if (!mode_q || dir_down_q) begin
            cnt_n = cnt_q - WIDTH'(1);
        end else begin
            cnt_n      = cnt_q + WIDTH'(1);
            dir_down_n = (cnt_q == (live_p_q - WIDTH'(1)));
        end

        for (int unsigned n = 0; n < CHANNELS; n++) begin
            pwm_n[n] = enable && (cnt_q < live_a_q[n]);
        end
        frame_end_n = enable && boundary_c;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            dir_down_q <= 1'b0;
            mode_q     <= 1'b0;
            stage_p_q  <= '0;
            stage_a_q  <= '0;
            live_p_q   <= '0;
            live_a_q   <= '0;
            pending    <= 1'b0;
            pwmOut     <= '0;
            frameEnd   <= 1'b0;
        end else begin
            cnt_q      <= cnt_n;
            dir_down_q <= dir_down_n;
            mode_q     <= mode_n;
            stage_p_q  <= stage_p_n;
            stage_a_q  <= stage_a_n;
            live_p_q   <= live_p_n;
            live_a_q   <= live_a_n;
            pending    <= pending_n;
            pwmOut     <= pwm_n;
            frameEnd   <= frame_end_n;
        end
    end

endmodule
